simm_ctl: RTL and testbench
===========================

SIMM_CTL -- requirements
Module: simm_ctl

Interface
REQ-001 SHALL have parameter T_RCD, 2, RAS-low cycles before column address is driven.
REQ-002 SHALL have parameter T_CAS, 2, CAS-low cycles per access and for the CBR RAS-low phase.
REQ-003 SHALL have parameter T_RP, 3, precharge cycles with RAS_/CAS_ high after every cycle.
REQ-004 SHALL have parameter REFRESH_PERIOD, 780, clocks between refresh requests.
REQ-005 SHALL have parameter INIT_CYCLES, 10000, power-up wait in clocks.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: ena  in  1  request; write  in  1  1=write 0=read; addr  in  24  byte address; wr_data  in  8  write byte.
REQ-008 SHALL have ports: ack  out  1  one-cycle accept pulse; busy  out  1  not idle; rd_data  out  8  read byte.
REQ-009 SHALL have ports: ram_addr  out  12  muxed row/col; ram_ras_, ram_cas_, ram_we_  out  1  active-low strobes; ram_dq  inout  8  data; dq_dir  out  1  1=driving ram_dq.

Function
REQ-010 SHALL implement states INIT, INIT_REF, IDLE, ROW, COL, CAS, PRE, REF_CAS, REF_RAS.
REQ-011 SHALL in INIT hold all strobes high and busy=1 for INIT_CYCLES clocks, then run 8 CBR refreshes (INIT_REF), then enter IDLE with busy=0.
REQ-012 SHALL in IDLE, on sampling ena=1 with no refresh pending, latch addr/write/wr_data and next cycle drive ack=1 (one cycle only), busy=1, ram_addr=addr[23:12], ram_ras_=0 (ROW).
REQ-013 SHALL after T_RCD ROW cycles drive ram_addr=addr[11:0], ram_we_=!write, dq_dir=write for one COL setup cycle, then hold ram_cas_=0 for T_CAS cycles.
REQ-014 SHALL drive ram_dq=latched wr_data while dq_dir=1, else high-impedance; ram_we_ falls no later than ram_cas_ (early write).
REQ-015 SHALL on a read sample ram_dq into rd_data on the last CAS-low cycle; rd_data holds until the next read completes; writes do not alter it.
REQ-016 SHALL then raise ram_ras_, ram_cas_, ram_we_, clear dq_dir, spend T_RP cycles in PRE, then return to IDLE with busy=0; ack-to-busy-low = 1+T_RCD+1+T_CAS+T_RP cycles (9 at defaults).
REQ-017 SHALL accept a new request in the first IDLE cycle if ena is still high; ena is ignored outside IDLE.
REQ-018 SHALL count every clock with a wrapping refresh counter, setting refresh_pending at count REFRESH_PERIOD-1; pending is cleared when REF_CAS is entered.
REQ-019 SHALL give refresh priority over ena when both occur in the same IDLE cycle; the request then waits, with no ack, until refresh completes.
REQ-020 SHALL run CBR refresh as: ram_cas_=0 one cycle (REF_CAS), then ram_ras_=0 for T_CAS cycles (REF_RAS), then PRE; ram_we_=1 throughout; busy=1; no ack.
REQ-021 SHALL never assert ram_ras_ and ram_cas_ low together except in REF_RAS or in CAS of an access.

Reset
REQ-022 SHALL on rst_n=0 immediately force ram_ras_=ram_cas_=ram_we_=1, dq_dir=0, ram_addr=0, ack=0, busy=1, rd_data=0, refresh counter=0, state=INIT, including mid-access.

Configuration
REQ-023 SHALL, with SIMM_CTL_REFRESH_EN defined, implement REQ-018 through REQ-020 and the INIT_REF phase.
REQ-024 SHALL, without SIMM_CTL_REFRESH_EN, omit the refresh counter and REF states, skip INIT_REF, and otherwise behave identically.

Verification
REQ-025 Reset release with INIT_CYCLES=20 -> busy=1 for 20 cycles plus 8 CBR cycles, all strobes high during INIT, then busy=0.
REQ-026 Write addr=0x123456, data=0xA5 -> ack once, ram_addr=0x123 then 0x456, ram_we_ low before ram_cas_, ram_dq=0xA5, busy low 9 cycles after ack.
REQ-027 Read back addr=0x123456 from a DRAM model -> rd_data=0xA5 when busy falls; a following write of 0x3C leaves rd_data=0xA5.
REQ-028 ena held high across accesses -> back-to-back accesses, exactly one ack per access, no ack while busy.
REQ-029 ena rises in the IDLE cycle that refresh becomes pending (REFRESH_PERIOD=50) -> CBR runs first, then ack; no CAS-before-RAS during the access.
REQ-030 rst_n low during CAS of a write -> strobes high and dq_dir=0 within the same cycle, busy=1, INIT restarts.

Source files
------------

// File: rtl/simm_ctl.sv
// simm_ctl: single-port FPM DRAM SIMM controller (RAS/CAS sequencing, early write, CBR refresh).
// Define SIMM_CTL_REFRESH_EN to build the refresh counter, CBR refresh states and the power-up refresh burst.
module simm_ctl #(
  parameter int T_RCD          = 2,
  parameter int T_CAS          = 2,
  parameter int T_RP           = 3,
  parameter int REFRESH_PERIOD = 780,
  parameter int INIT_CYCLES    = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        write,
  input  logic [23:0] addr,
  input  logic [7:0]  wr_data,
  output logic        ack,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic [11:0] ram_addr,
  output logic        ram_ras_,
  output logic        ram_cas_,
  output logic        ram_we_,
  inout  wire  [7:0]  ram_dq,
  output logic        dq_dir
);

  localparam logic [3:0] ST_INIT     = 4'd0;
  localparam logic [3:0] ST_INIT_REF = 4'd1;
  localparam logic [3:0] ST_IDLE     = 4'd2;
  localparam logic [3:0] ST_ROW      = 4'd3;
  localparam logic [3:0] ST_COL      = 4'd4;
  localparam logic [3:0] ST_CAS      = 4'd5;
  localparam logic [3:0] ST_PRE      = 4'd6;
  localparam logic [3:0] ST_REF_CAS  = 4'd7;
  localparam logic [3:0] ST_REF_RAS  = 4'd8;

  // One shared phase counter; wide enough for the power-up wait.
  localparam int CW = 16;

  if (T_RCD < 0 || T_CAS < 1 || T_RP < 1 || REFRESH_PERIOD < 2 ||
      INIT_CYCLES < 1 || INIT_CYCLES > 65536) begin : g_bad_params
    $error("simm_ctl: unsupported timing parameter set");
  end

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rd_data_q, rd_data_d;

`ifdef SIMM_CTL_REFRESH_EN
  localparam int RW = $clog2(REFRESH_PERIOD);
  localparam logic [3:0] INIT_REFRESHES = 4'd8;

  logic [RW-1:0] rc_q, rc_d;
  logic          pend_q, pend_d;
  logic [3:0]    irf_q, irf_d;

  always_comb begin
    rc_d   = rc_q + RW'(1);
    pend_d = pend_q;
    if (state_q == ST_IDLE && pend_q) pend_d = 1'b0;
    // A wrap on the same edge that a refresh is taken re-arms pending.
    if (rc_q == RW'(REFRESH_PERIOD - 1)) begin
      rc_d   = '0;
      pend_d = 1'b1;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
`ifdef SIMM_CTL_REFRESH_EN
    irf_d     = irf_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CW'(INIT_CYCLES - 1)) begin
          cnt_d = '0;
`ifdef SIMM_CTL_REFRESH_EN
          state_d = ST_INIT_REF;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_INIT_REF: begin
        state_d = ST_REF_RAS;
        cnt_d   = '0;
`ifdef SIMM_CTL_REFRESH_EN
        irf_d   = irf_q + 4'd1;
`endif
      end
      ST_IDLE: begin
`ifdef SIMM_CTL_REFRESH_EN
        if (pend_q) begin
          state_d = ST_REF_CAS;
        end else
`endif
        if (ena) begin
          state_d = ST_ROW;
          cnt_d   = '0;
          addr_d  = addr;
          write_d = write;
          wdata_d = wr_data;
        end
      end
      ST_ROW: begin
        if (cnt_q == CW'(T_RCD)) begin
          state_d = ST_COL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COL: begin
        state_d = ST_CAS;
        cnt_d   = '0;
      end
      ST_CAS: begin
        if (cnt_q == CW'(T_CAS - 1)) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          if (!write_q) rd_data_d = ram_dq;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REF_CAS: begin
        state_d = ST_REF_RAS;
        cnt_d   = '0;
      end
      ST_REF_RAS: begin
        if (cnt_q == CW'(T_CAS - 1)) begin
          state_d = ST_PRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRE: begin
        if (cnt_q == CW'(T_RP - 1)) begin
          cnt_d = '0;
`ifdef SIMM_CTL_REFRESH_EN
          state_d = (irf_q < INIT_REFRESHES) ? ST_INIT_REF : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      // NOTE: request and read-data registers are reset too: rd_data is visible and must read 0 after reset.
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rd_data_q <= '0;
`ifdef SIMM_CTL_REFRESH_EN
      rc_q      <= '0;
      pend_q    <= 1'b0;
      irf_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
`ifdef SIMM_CTL_REFRESH_EN
      rc_q      <= rc_d;
      pend_q    <= pend_d;
      irf_q     <= irf_d;
`endif
    end
  end

  // Strobes decode straight from state so an async reset releases the bus in the same cycle.
  logic drive_dq;
  always_comb begin
    drive_dq = (state_q == ST_COL || state_q == ST_CAS) && write_q;
    busy     = (state_q != ST_IDLE);
    ack      = (state_q == ST_ROW) && (cnt_q == '0);
    ram_ras_ = !(state_q == ST_ROW || state_q == ST_COL || state_q == ST_CAS ||
                 state_q == ST_REF_RAS);
    ram_cas_ = !(state_q == ST_CAS || state_q == ST_INIT_REF || state_q == ST_REF_CAS ||
                 state_q == ST_REF_RAS);
    ram_we_  = !drive_dq;
    dq_dir   = drive_dq;
    ram_addr = '0;
    if (state_q == ST_ROW) ram_addr = addr_q[23:12];
    else if (state_q == ST_COL || state_q == ST_CAS) ram_addr = addr_q[11:0];
  end

  assign ram_dq  = dq_dir ? wdata_q : 8'hzz;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_simm_ctl.sv
// tb_simm_ctl: self-checking bench for simm_ctl with a transaction-level model and a DRAM array model.
// Honours SIMM_CTL_REFRESH_EN the same way the design does.
module tb_simm_ctl;
  localparam int T_RCD          = 2;
  localparam int T_CAS          = 2;
  localparam int T_RP           = 3;
  localparam int REFRESH_PERIOD = 50;
  localparam int INIT_CYCLES    = 20;
  localparam int ACC_LEN        = 1 + T_RCD + 1 + T_CAS + T_RP;
  localparam int REF_LEN        = 1 + T_CAS + T_RP;
`ifdef SIMM_CTL_REFRESH_EN
  localparam bit REF_EN    = 1'b1;
  localparam int INIT_BUSY = 68;  // 20 wait cycles + 8 refreshes of 6 cycles
`else
  localparam bit REF_EN    = 1'b0;
  localparam int INIT_BUSY = 20;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, write;
  logic [23:0] addr;
  logic [7:0]  wr_data;
  logic        ack, busy, dq_dir;
  logic [7:0]  rd_data;
  logic [11:0] ram_addr;
  logic        ram_ras_, ram_cas_, ram_we_;
  wire  [7:0]  ram_dq;

  int n_cmp  = 0;
  int n_fail = 0;

  simm_ctl #(
    .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP),
    .REFRESH_PERIOD(REFRESH_PERIOD), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .write(write), .addr(addr), .wr_data(wr_data),
    .ack(ack), .busy(busy), .rd_data(rd_data), .ram_addr(ram_addr),
    .ram_ras_(ram_ras_), .ram_cas_(ram_cas_), .ram_we_(ram_we_), .ram_dq(ram_dq), .dq_dir(dq_dir)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // ---------------- DRAM array model ----------------
  logic [7:0]  dmem [logic [23:0]];
  logic [11:0] d_row = '0;
  logic [11:0] d_col = '0;
  logic        d_cbr = 1'b0;
  logic [7:0]  d_q   = '0;

  initial forever begin
    @(negedge ram_ras_);
    #1 d_row = ram_addr;
  end
  initial forever begin
    @(posedge ram_ras_);
    d_cbr = 1'b0;
  end
  initial forever begin
    @(negedge ram_cas_);
    #1;
    if (ram_ras_) begin
      d_cbr = 1'b1;
    end else begin
      d_col = ram_addr;
      if (!ram_we_) dmem[{d_row, d_col}] = ram_dq;
      d_q = dmem.exists({d_row, d_col}) ? dmem[{d_row, d_col}] : dflt({d_row, d_col});
    end
  end
  assign ram_dq = (!ram_ras_ && !ram_cas_ && ram_we_ && !d_cbr) ? d_q : 8'hzz;

  // ---------------- transaction-level model ----------------
  typedef enum {K_INIT, K_IREF, K_IDLE, K_ACC, K_REF} kind_t;
  kind_t       m_kind;
  int          m_k, m_rc, m_irf;
  bit          m_pend, m_write;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata, m_rd;
  logic [7:0]  mmem [logic [23:0]];

  task automatic model_reset();
    m_kind = K_INIT; m_k = 0; m_rc = 0; m_irf = 0; m_pend = 0;
    m_write = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
  endtask

  task automatic model_step();
    bit wrap;
    wrap = (m_rc == REFRESH_PERIOD - 1);
    m_rc = wrap ? 0 : m_rc + 1;
    case (m_kind)
      K_INIT:
        if (m_k == INIT_CYCLES - 1) begin
          m_k = 0; m_irf = 0;
          m_kind = REF_EN ? K_IREF : K_IDLE;
        end else m_k++;
      K_IDLE:
        if (REF_EN && m_pend) begin
          m_kind = K_REF; m_k = 0; m_pend = 0;
        end else if (ena) begin
          m_kind = K_ACC; m_k = 0;
          m_addr = addr; m_write = write; m_wdata = wr_data;
          if (write) mmem[addr] = wr_data;
        end
      K_ACC: begin
        if (!m_write && m_k == T_RCD + 1 + T_CAS)
          m_rd = mmem.exists(m_addr) ? mmem[m_addr] : dflt(m_addr);
        if (m_k == ACC_LEN - 1) m_kind = K_IDLE;
        else m_k++;
      end
      default:
        if (m_k == REF_LEN - 1) begin
          m_k = 0;
          if (m_kind == K_IREF) begin
            m_irf++;
            m_kind = (m_irf == 8) ? K_IDLE : K_IREF;
          end else m_kind = K_IDLE;
        end else m_k++;
    endcase
    if (REF_EN && wrap) m_pend = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every cycle out of reset: all outputs against what the model says this cycle must show.
  task automatic compare_cycle();
    bit acc, rf, e_ras, e_cas, e_drv;
    int k;
    acc   = (m_kind == K_ACC);
    rf    = (m_kind == K_REF) || (m_kind == K_IREF);
    k     = m_k;
    e_ras = !((acc && k <= T_RCD + 1 + T_CAS) || (rf && k >= 1 && k <= T_CAS));
    e_cas = !((acc && k >= T_RCD + 2 && k <= T_RCD + 1 + T_CAS) || (rf && k <= T_CAS));
    e_drv = acc && m_write && k >= T_RCD + 1 && k <= T_RCD + 1 + T_CAS;
    check("busy", busy, m_kind != K_IDLE);
    check("ack", ack, acc && k == 0);
    check("ras_", ram_ras_, e_ras);
    check("cas_", ram_cas_, e_cas);
    check("we_", ram_we_, !e_drv);
    check("dq_dir", dq_dir, e_drv);
    check("rd_data", rd_data, m_rd);
    if (m_kind == K_INIT) check("init_addr", ram_addr, 0);
    if (acc && k <= T_RCD) check("row_addr", ram_addr, m_addr[23:12]);
    if (acc && k > T_RCD && k <= T_RCD + 1 + T_CAS) check("col_addr", ram_addr, m_addr[11:0]);
    if (e_drv) check("ram_dq", ram_dq, m_wdata);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) compare_cycle();
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ack();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    check("ack_seen", ack, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic do_access(input bit w, input logic [23:0] a, input logic [7:0] d);
    write = w; addr = a; wr_data = d; ena = 1'b1;
    wait_ack();
    ena = 1'b0;
    wait_idle();
  endtask

  task automatic measure_init();
    int n;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("init_busy_cycles", n, INIT_BUSY);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ras_"}, ram_ras_, 1);
    check({tag, "_cas_"}, ram_cas_, 1);
    check({tag, "_we_"}, ram_we_, 1);
    check({tag, "_dq_dir"}, dq_dir, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_addr"}, ram_addr, 0);
  endtask

  logic [23:0] b2b_addr [3] = '{24'h000001, 24'hFFFFFF, 24'hFFFFFF};
  logic [7:0]  b2b_data [3] = '{8'h11, 8'hEE, 8'h00};
  bit          b2b_wr   [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    int first_we, first_cas, busy_low, acks, n_ack, idx, cnt;
    int ack_t [3];
    logic [11:0] row0, col;
    logic [7:0]  dq;
    bit prev_busy, found;

    rst_n = 1'b0; ena = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    measure_init();

    // Write 0x123456 <= 0xA5, traced cycle by cycle from the ack.
    wait_idle();
    write = 1'b1; addr = 24'h123456; wr_data = 8'hA5; ena = 1'b1;
    wait_ack();
    ena = 1'b0;
    first_we = -1; first_cas = -1; busy_low = -1; acks = 0;
    row0 = ram_addr; col = '0; dq = '0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (ack) acks++;
      if (!ram_we_ && first_we < 0) first_we = k;
      if (!ram_cas_ && first_cas < 0) begin
        first_cas = k; col = ram_addr; dq = ram_dq;
      end
      if (!busy && busy_low < 0) busy_low = k;
    end
    check("wr_row", row0, 12'h123);
    check("wr_col", col, 12'h456);
    check("wr_first_we", first_we, 3);
    check("wr_first_cas", first_cas, 4);
    check("wr_dq", dq, 8'hA5);
    check("wr_busy_low", busy_low, 9);
    check("wr_ack_count", acks, 1);

    // Read back, then a write must leave rd_data alone, then read the new byte.
    wait_idle();
    do_access(1'b0, 24'h123456, 8'h00);
    check("rd_a5", rd_data, 8'hA5);
    do_access(1'b1, 24'h123456, 8'h3C);
    check("rd_kept_after_wr", rd_data, 8'hA5);
    do_access(1'b0, 24'h123456, 8'h00);
    check("rd_3c", rd_data, 8'h3C);

    // ena held high across three accesses.
    idx = 0; n_ack = 0;
    write = b2b_wr[0]; addr = b2b_addr[0]; wr_data = b2b_data[0]; ena = 1'b1;
    prev_busy = busy;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack) begin
        check("b2b_ack_after_idle", prev_busy, 0);
        ack_t[n_ack] = i;
        n_ack++;
        if (n_ack == 3) begin
          ena = 1'b0;
          break;
        end
        idx++;
        write = b2b_wr[idx]; addr = b2b_addr[idx]; wr_data = b2b_data[idx];
      end
      prev_busy = busy;
    end
    check("b2b_ack_count", n_ack, 3);
`ifndef SIMM_CTL_REFRESH_EN
    check("b2b_gap1", ack_t[1] - ack_t[0], 10);
    check("b2b_gap2", ack_t[2] - ack_t[1], 10);
`endif
    wait_idle();
    check("b2b_rd", rd_data, 8'hEE);

`ifdef SIMM_CTL_REFRESH_EN
    // ena rises in the very IDLE cycle a refresh is pending: CBR first, ack afterwards.
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_kind == K_IDLE && m_pend) begin
        found = 1'b1;
        break;
      end
    end
    check("pend_found", found, 1);
    write = 1'b0; addr = 24'h000001; ena = 1'b1;
    @(negedge clk);
    check("ref_cas_first", ram_cas_, 0);
    check("ref_ras_high", ram_ras_, 1);
    check("ref_no_ack", ack, 0);
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cnt++;
      if (ack) break;
    end
    ena = 1'b0;
    check("ref_then_ack_at", cnt, 8);
    wait_idle();
    check("ref_rd", rd_data, 8'h11);
`endif

    // Reset in the middle of a write CAS phase.
    wait_idle();
    write = 1'b1; addr = 24'h00ABCD; wr_data = 8'h77; ena = 1'b1;
    wait_ack();
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ram_cas_) break;
      @(negedge clk);
    end
    check("midcas_reached", ram_cas_, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure_init();
    wait_idle();
    do_access(1'b0, 24'h00ABCD, 8'h00);
    check("post_rst_rd", rd_data, 8'h77);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
